sdc_cmd_sequencer: RTL and testbench
====================================

Name: sdc_cmd_sequencer

Overview:
- Wishbone master that runs one complete SD command transaction through the SD controller register slave.
- Sequence: program command word and argument, poll command interrupt events, read the response words, clear events, return result to requester.
- Sits between firmware/boot logic (simple valid/ready request port) and the SD controller register block.
- Register slave acks in the same cycle as cyc&&stb, but this master tolerates any ack latency.

Parameters:
POLL_LIMIT, 65535, max event-register reads before timeout (1..2^POLL_W-1)
POLL_W, 16, poll counter width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
req_valid  in  1  request present
req_ready  out  1  sequencer idle, accepts request
req_cmd  in  14  value for command register (word 0x01)
req_arg  in  32  value for argument register (word 0x00)
req_long  in  1  1 = 120-bit response (4 reads), 0 = 32-bit (1 read)
done  out  1  one-cycle completion pulse
done_events  out  5  command event bits captured at end of poll
done_timeout  out  1  poll limit reached with no event
done_resp  out  120  captured response
wb_addr  out  8  byte address (word index << 2)
wb_dout  out  32  write data
wb_din  in  32  read data
wb_dm  out  4  byte enables
wb_cyc  out  1  bus cycle
wb_stb  out  1  strobe
wb_we  out  1  write enable
wb_ack  in  1  acknowledge

Behaviour:
- Reset (rst low, async): state IDLE; all outputs 0 except req_ready=1; done_resp/done_events/done_timeout cleared; poll counter 0. Reset mid-access drops cyc/stb immediately.
- States: IDLE, WR_CMD, WR_ARG, POLL, RD_RSP, CLR, DONE.
- IDLE: req_ready=1. On req_valid: latch cmd/arg/long, clear done_resp/done_events/done_timeout, go to WR_CMD. req_ready=0 in all other states.
- Bus access rule:
  - In each access state, cyc=stb=1 with stable addr/we/dout/dm until wb_ack is sampled high.
  - The cycle after ack: cyc=stb=0 for exactly one cycle (gap), then the next access begins.
  - Writes use wb_dm=4'hF. Reads use wb_we=0, wb_dm=4'hF.
- WR_CMD: write addr 0x04, data {18'b0, cmd} -> WR_ARG.
- WR_ARG: write addr 0x00, data arg. This write is what starts the command in the controller -> POLL.
- POLL: read addr 0x34.
  - wb_din[4:0] != 0: capture into done_events -> RD_RSP.
  - Otherwise increment poll counter. If counter reaches POLL_LIMIT, set done_timeout=1, done_events=0 -> CLR (no response read). Else repeat POLL.
- RD_RSP:
  - Short response: one read of addr 0x08 -> done_resp[31:0]; upper bits stay 0.
  - Long response: reads 0x08, 0x0C, 0x10, 0x14 in order -> [31:0], [63:32], [95:64], and wb_din[23:0] -> [119:96].
  - Then -> CLR.
- CLR: write addr 0x34, data 0 (clears latched events) -> DONE.
- DONE: done=1 for one cycle, outputs valid and held until the next request is accepted -> IDLE.
- Poll counter resets to 0 on every accepted request.
- Minimum latency, zero-wait ack, short response: request accepted at cycle 0, done at cycle 12.
  - Derivation: WR_CMD, WR_ARG, one POLL hit, RD_RSP, CLR = 5 accesses; each takes 1 cycle plus a 1-cycle gap (10 cycles); plus the IDLE accept cycle and the DONE cycle.
- req_valid while busy is ignored; the requester holds it until req_ready.
- wb_ack while cyc=0 is ignored.

Test Plan:
- Short cmd: req_cmd=14'h0119, req_arg=32'h0000_1000, req_long=0; slave returns events 5'h01 on 3rd poll, resp0=32'h0000_0900 -> bus order 0x04(W 0x119), 0x00(W 0x1000), 0x34 x3, 0x08, 0x34(W 0). Then done=1 with done_events=1, done_resp=120'h900, done_timeout=0.
- Long cmd: req_long=1; slave words 0x11111111, 0x22222222, 0x33333333, 0xAB445566 -> done_resp={24'h445566, 32'h33333333, 32'h22222222, 32'h11111111}.
- Timeout: POLL_LIMIT=4, events always 0 -> exactly 4 reads of 0x34, then the clear write. done_timeout=1, done_events=0, no read of 0x08.
- Wait-state slave: ack delayed 3 cycles on every access -> addr/dout/we stable while stb high. Exactly one idle cycle between accesses. Same captured result as the short-cmd case.
- Reset mid-poll: assert rst low during a POLL access -> wb_cyc=0 immediately, req_ready=1 after release, done never pulses. A following request completes normally.
- Back-to-back: req_valid held high across completion -> second request accepted the cycle after DONE. done_resp cleared to 0 on acceptance.

Source files
------------

// File: rtl/sdc_cmd_sequencer.sv
// Wishbone master that runs one SD command through the controller register slave:
// write command and argument, poll events, read the response, clear events, report.
module sdc_cmd_sequencer #(
    parameter int POLL_LIMIT = 65535,
    parameter int POLL_W     = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [13:0]  req_cmd,
    input  logic [31:0]  req_arg,
    input  logic         req_long,
    output logic         done,
    output logic [4:0]   done_events,
    output logic         done_timeout,
    output logic [119:0] done_resp,
    output logic [7:0]   wb_addr,
    output logic [31:0]  wb_dout,
    input  logic [31:0]  wb_din,
    output logic [3:0]   wb_dm,
    output logic         wb_cyc,
    output logic         wb_stb,
    output logic         wb_we,
    input  logic         wb_ack
);

    typedef enum logic [2:0] {
        IDLE,
        WR_CMD,
        WR_ARG,
        POLL,
        RD_RSP,
        CLR,
        DONE
    } state_t;

    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_LIMIT - 1);
    localparam logic [POLL_W-1:0] POLL_ONE  = POLL_W'(1);

    localparam logic [7:0] ADDR_ARG = 8'h00;
    localparam logic [7:0] ADDR_CMD = 8'h04;
    localparam logic [7:0] ADDR_RSP = 8'h08;
    localparam logic [7:0] ADDR_EVT = 8'h34;

    state_t             state_q, state_d;
    logic               gap_q, gap_d;
    logic [13:0]        cmd_q, cmd_d;
    logic [31:0]        arg_q, arg_d;
    logic               long_q, long_d;
    logic [POLL_W-1:0]  poll_cnt_q, poll_cnt_d;
    logic [1:0]         rsp_idx_q, rsp_idx_d;
    logic [119:0]       resp_q, resp_d;
    logic [4:0]         events_q, events_d;
    logic               timeout_q, timeout_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            gap_q      <= 1'b0;
            cmd_q      <= '0;
            arg_q      <= '0;
            long_q     <= 1'b0;
            poll_cnt_q <= '0;
            rsp_idx_q  <= '0;
            resp_q     <= '0;
            events_q   <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            cmd_q      <= cmd_d;
            arg_q      <= arg_d;
            long_q     <= long_d;
            poll_cnt_q <= poll_cnt_d;
            rsp_idx_q  <= rsp_idx_d;
            resp_q     <= resp_d;
            events_q   <= events_d;
            timeout_q  <= timeout_d;
        end
    end

    // gap_q marks the mandatory idle bus cycle that follows every acknowledged access.
    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        cmd_d      = cmd_q;
        arg_d      = arg_q;
        long_d     = long_q;
        poll_cnt_d = poll_cnt_q;
        rsp_idx_d  = rsp_idx_q;
        resp_d     = resp_q;
        events_d   = events_q;
        timeout_d  = timeout_q;
        req_ready  = 1'b0;
        done       = 1'b0;
        wb_cyc     = 1'b0;
        wb_stb     = 1'b0;
        wb_we      = 1'b0;
        wb_addr    = 8'h00;
        wb_dout    = 32'h0;
        wb_dm      = 4'h0;

        if (state_q != IDLE && gap_q) begin
            gap_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        cmd_d      = req_cmd;
                        arg_d      = req_arg;
                        long_d     = req_long;
                        poll_cnt_d = '0;
                        rsp_idx_d  = '0;
                        resp_d     = '0;
                        events_d   = '0;
                        timeout_d  = 1'b0;
                        gap_d      = 1'b0;
                        state_d    = WR_CMD;
                    end
                end
                WR_CMD: begin
                    wb_cyc  = 1'b1;
                    wb_stb  = 1'b1;
                    wb_we   = 1'b1;
                    wb_dm   = 4'hF;
                    wb_addr = ADDR_CMD;
                    wb_dout = {18'b0, cmd_q};
                    if (wb_ack) begin
                        gap_d   = 1'b1;
                        state_d = WR_ARG;
                    end
                end
                WR_ARG: begin
                    wb_cyc  = 1'b1;
                    wb_stb  = 1'b1;
                    wb_we   = 1'b1;
                    wb_dm   = 4'hF;
                    wb_addr = ADDR_ARG;
                    wb_dout = arg_q;
                    if (wb_ack) begin
                        gap_d   = 1'b1;
                        state_d = POLL;
                    end
                end
                POLL: begin
                    wb_cyc  = 1'b1;
                    wb_stb  = 1'b1;
                    wb_dm   = 4'hF;
                    wb_addr = ADDR_EVT;
                    if (wb_ack) begin
                        gap_d = 1'b1;
                        if (wb_din[4:0] != 5'b0) begin
                            events_d = wb_din[4:0];
                            state_d  = RD_RSP;
                        end else if (poll_cnt_q == POLL_LAST) begin
                            // Give up: no response read, but the events are still cleared.
                            poll_cnt_d = poll_cnt_q + POLL_ONE;
                            timeout_d  = 1'b1;
                            events_d   = '0;
                            state_d    = CLR;
                        end else begin
                            poll_cnt_d = poll_cnt_q + POLL_ONE;
                        end
                    end
                end
                RD_RSP: begin
                    wb_cyc  = 1'b1;
                    wb_stb  = 1'b1;
                    wb_dm   = 4'hF;
                    wb_addr = ADDR_RSP + {4'b0000, rsp_idx_q, 2'b00};
                    if (wb_ack) begin
                        gap_d = 1'b1;
                        case (rsp_idx_q)
                            2'd0:    resp_d[31:0]   = wb_din;
                            2'd1:    resp_d[63:32]  = wb_din;
                            2'd2:    resp_d[95:64]  = wb_din;
                            default: resp_d[119:96] = wb_din[23:0];
                        endcase
                        if (!long_q || rsp_idx_q == 2'd3) begin
                            state_d = CLR;
                        end else begin
                            rsp_idx_d = rsp_idx_q + 2'd1;
                        end
                    end
                end
                CLR: begin
                    wb_cyc  = 1'b1;
                    wb_stb  = 1'b1;
                    wb_we   = 1'b1;
                    wb_dm   = 4'hF;
                    wb_addr = ADDR_EVT;
                    wb_dout = 32'h0;
                    if (wb_ack) begin
                        gap_d   = 1'b1;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign done_events  = events_q;
    assign done_timeout = timeout_q;
    assign done_resp    = resp_q;

endmodule

// File: tb/tb_sdc_cmd_sequencer.sv
// Self-checking bench for sdc_cmd_sequencer: a behavioural register slave with
// configurable ack latency plus scoreboards for bus accesses and completions.
module tb_sdc_cmd_sequencer;

    localparam int POLL_LIMIT = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [13:0]  req_cmd = '0;
    logic [31:0]  req_arg = '0;
    logic         req_long = 1'b0;
    logic         done;
    logic [4:0]   done_events;
    logic         done_timeout;
    logic [119:0] done_resp;
    logic [7:0]   wb_addr;
    logic [31:0]  wb_dout;
    logic [31:0]  wb_din = '0;
    logic [3:0]   wb_dm;
    logic         wb_cyc;
    logic         wb_stb;
    logic         wb_we;
    logic         wb_ack = 1'b0;

    always #5 clk = ~clk;

    sdc_cmd_sequencer #(.POLL_LIMIT(POLL_LIMIT), .POLL_W(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_arg(req_arg), .req_long(req_long),
        .done(done), .done_events(done_events), .done_timeout(done_timeout), .done_resp(done_resp),
        .wb_addr(wb_addr), .wb_dout(wb_dout), .wb_din(wb_din), .wb_dm(wb_dm),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_ack(wb_ack)
    );

    typedef struct packed {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] data;
    } bus_t;

    typedef struct packed {
        logic [4:0]   ev;
        logic         to;
        logic [119:0] resp;
    } res_t;

    bus_t        exp_bus[$];
    res_t        exp_done[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          ack_delay = 0;
    int          hit_at = 1;
    logic [4:0]  hit_ev = 5'h01;
    logic [31:0] words[4];
    int          slave_polls = 0;
    int          done_count = 0;

    task automatic push_wr(input logic [7:0] addr, input logic [31:0] data);
        bus_t b;
        b.we = 1'b1; b.addr = addr; b.data = data;
        exp_bus.push_back(b);
    endtask

    task automatic push_rd(input logic [7:0] addr);
        bus_t b;
        b.we = 1'b0; b.addr = addr; b.data = 32'h0;
        exp_bus.push_back(b);
    endtask

    task automatic push_done(input logic [4:0] ev, input logic to, input logic [119:0] resp);
        res_t r;
        r.ev = ev; r.to = to; r.resp = resp;
        exp_done.push_back(r);
    endtask

    task automatic push_cmd_writes(input logic [13:0] cmd, input logic [31:0] arg);
        push_wr(8'h04, {18'b0, cmd});
        push_wr(8'h00, arg);
    endtask

    // Slave model and bus monitor: acks after ack_delay wait cycles, checks the
    // idle gap and signal stability, and scores every access and completion.
    task automatic run_monitor();
        int   wait_cnt = 0;
        int   gap_cnt = 0;
        bit   in_txn = 1'b0;
        bus_t got, hold, eb;
        res_t er;
        forever begin
            @(negedge clk);
            wb_ack = 1'b0;
            if (rst !== 1'b1) begin
                in_txn = 1'b0; wait_cnt = 0; gap_cnt = 0;
            end else begin
                if (done === 1'b1) begin
                    done_count++;
                    in_txn = 1'b0;
                    n_checks++;
                    if (exp_done.size() == 0) begin
                        n_fail++;
                        $display("[TB] FAIL done_unexpected: got done=1 events=%h timeout=%b, expected no completion", done_events, done_timeout);
                    end else begin
                        er = exp_done.pop_front();
                        if (done_events !== er.ev || done_timeout !== er.to || done_resp !== er.resp) begin
                            n_fail++;
                            $display("[TB] FAIL done_result: got ev=%h to=%b resp=%h, expected ev=%h to=%b resp=%h",
                                     done_events, done_timeout, done_resp, er.ev, er.to, er.resp);
                        end
                    end
                end
                if (wb_cyc === 1'b1 && wb_stb === 1'b1) begin
                    got.we = wb_we; got.addr = wb_addr; got.data = wb_dout;
                    if (wait_cnt == 0) begin
                        hold = got;
                        if (in_txn) begin
                            n_checks++;
                            if (gap_cnt != 1) begin
                                n_fail++;
                                $display("[TB] FAIL bus_gap: got %0d idle cycles, expected 1", gap_cnt);
                            end
                        end
                        n_checks++;
                        if (wb_dm !== 4'hF) begin
                            n_fail++;
                            $display("[TB] FAIL byte_enables: got %h, expected f", wb_dm);
                        end
                        in_txn = 1'b1;
                    end else begin
                        n_checks++;
                        if (got !== hold) begin
                            n_fail++;
                            $display("[TB] FAIL bus_stable: got we=%b addr=%h data=%h, expected we=%b addr=%h data=%h",
                                     got.we, got.addr, got.data, hold.we, hold.addr, hold.data);
                        end
                    end
                    if (wait_cnt == ack_delay) begin
                        wb_ack = 1'b1;
                        wait_cnt = 0;
                        gap_cnt = 0;
                        n_checks++;
                        if (exp_bus.size() == 0) begin
                            n_fail++;
                            $display("[TB] FAIL bus_unexpected: got we=%b addr=%h data=%h, expected no access", got.we, got.addr, got.data);
                        end else begin
                            eb = exp_bus.pop_front();
                            if (got.we !== eb.we || got.addr !== eb.addr || (eb.we && got.data !== eb.data)) begin
                                n_fail++;
                                $display("[TB] FAIL bus_access: got we=%b addr=%h data=%h, expected we=%b addr=%h data=%h",
                                         got.we, got.addr, got.data, eb.we, eb.addr, eb.data);
                            end
                        end
                        if (got.we !== 1'b1) begin
                            case (got.addr)
                                8'h34: begin
                                    slave_polls++;
                                    if (hit_at != 0 && slave_polls == hit_at) wb_din = 32'hFFFF_FFE0 | {27'h0, hit_ev};
                                    else wb_din = 32'hABCD_0000;
                                end
                                8'h08: wb_din = words[0];
                                8'h0C: wb_din = words[1];
                                8'h10: wb_din = words[2];
                                8'h14: wb_din = words[3];
                                default: wb_din = 32'hDEAD_BEEF;
                            endcase
                        end else if (got.addr == 8'h00) begin
                            slave_polls = 0;
                        end
                    end else begin
                        wait_cnt++;
                    end
                end else begin
                    wait_cnt = 0;
                    gap_cnt++;
                end
            end
        end
    endtask

    // Drives one request and waits for done; lat counts cycles from the accept cycle.
    task automatic run_cmd(input logic [13:0] cmd, input logic [31:0] arg, input logic lng,
                           input bit hold, output int lat);
        int guard = 0;
        while (req_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        req_cmd = cmd; req_arg = arg; req_long = lng; req_valid = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!hold) req_valid = 1'b0;
        end while (done !== 1'b1 && lat < 400);
        if (done !== 1'b1) begin
            n_checks++; n_fail++;
            $display("[TB] FAIL done_wait: got no done after %0d cycles, expected completion", lat);
            lat = -1;
        end
        #1;
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready: got %b, expected 1", req_ready); end
        n_checks++;
        if (wb_cyc !== 1'b0 || wb_stb !== 1'b0 || wb_we !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_bus: got cyc=%b stb=%b we=%b, expected 0 0 0", wb_cyc, wb_stb, wb_we);
        end
        n_checks++;
        if (done !== 1'b0 || done_timeout !== 1'b0 || done_events !== 5'h0) begin
            n_fail++; $display("[TB] FAIL reset_done: got done=%b to=%b ev=%h, expected 0 0 0", done, done_timeout, done_events);
        end
        n_checks++;
        if (done_resp !== 120'h0) begin n_fail++; $display("[TB] FAIL reset_resp: got %h, expected 0", done_resp); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || wb_cyc !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_release: got ready=%b cyc=%b, expected 1 0", req_ready, wb_cyc);
        end
        #1;
    endtask

    task automatic test_min_latency();
        int lat;
        ack_delay = 0; hit_at = 1; hit_ev = 5'h04; words[0] = 32'hCAFE_0001;
        push_cmd_writes(14'h0011, 32'h1234_5678);
        push_rd(8'h34); push_rd(8'h08); push_wr(8'h34, 32'h0);
        push_done(5'h04, 1'b0, {88'h0, 32'hCAFE_0001});
        run_cmd(14'h0011, 32'h1234_5678, 1'b0, 1'b0, lat);
        n_checks++;
        if (lat + 1 != 12) begin n_fail++; $display("[TB] FAIL min_latency: got %0d cycles, expected 12", lat + 1); end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || req_ready !== 1'b1 || done_resp !== {88'h0, 32'hCAFE_0001}) begin
            n_fail++; $display("[TB] FAIL done_hold: got done=%b ready=%b resp=%h, expected 0 1 cafe0001", done, req_ready, done_resp);
        end
        n_checks++;
        if (exp_bus.size() != 0 || exp_done.size() != 0) begin
            n_fail++; $display("[TB] FAIL min_latency_drain: got %0d/%0d pending, expected 0/0", exp_bus.size(), exp_done.size());
        end
    endtask

    task automatic test_short(input int delay, input int exp_lat);
        int lat;
        ack_delay = delay; hit_at = 3; hit_ev = 5'h01; words[0] = 32'h0000_0900;
        push_cmd_writes(14'h0119, 32'h0000_1000);
        repeat (3) push_rd(8'h34);
        push_rd(8'h08); push_wr(8'h34, 32'h0);
        push_done(5'h01, 1'b0, 120'h900);
        run_cmd(14'h0119, 32'h0000_1000, 1'b0, 1'b0, lat);
        n_checks++;
        if (lat + 1 != exp_lat) begin n_fail++; $display("[TB] FAIL short_latency: got %0d cycles, expected %0d", lat + 1, exp_lat); end
        @(negedge clk);
        n_checks++;
        if (exp_bus.size() != 0 || exp_done.size() != 0) begin
            n_fail++; $display("[TB] FAIL short_drain: got %0d/%0d pending, expected 0/0", exp_bus.size(), exp_done.size());
        end
        ack_delay = 0;
    endtask

    task automatic test_long();
        int lat;
        ack_delay = 0; hit_at = 1; hit_ev = 5'h03;
        words[0] = 32'h1111_1111; words[1] = 32'h2222_2222; words[2] = 32'h3333_3333; words[3] = 32'hAB44_5566;
        push_cmd_writes(14'h0229, 32'hA5A5_0000);
        push_rd(8'h34); push_rd(8'h08); push_rd(8'h0C); push_rd(8'h10); push_rd(8'h14);
        push_wr(8'h34, 32'h0);
        push_done(5'h03, 1'b0, {24'h445566, 32'h33333333, 32'h22222222, 32'h11111111});
        run_cmd(14'h0229, 32'hA5A5_0000, 1'b1, 1'b0, lat);
        n_checks++;
        if (lat + 1 != 18) begin n_fail++; $display("[TB] FAIL long_latency: got %0d cycles, expected 18", lat + 1); end
        @(negedge clk);
        n_checks++;
        if (exp_bus.size() != 0 || exp_done.size() != 0) begin
            n_fail++; $display("[TB] FAIL long_drain: got %0d/%0d pending, expected 0/0", exp_bus.size(), exp_done.size());
        end
    endtask

    task automatic test_timeout();
        int lat;
        ack_delay = 0; hit_at = 0;
        push_cmd_writes(14'h0033, 32'h0000_0042);
        repeat (POLL_LIMIT) push_rd(8'h34);
        push_wr(8'h34, 32'h0);
        push_done(5'h00, 1'b1, 120'h0);
        run_cmd(14'h0033, 32'h0000_0042, 1'b1, 1'b0, lat);
        n_checks++;
        if (lat + 1 != 16) begin n_fail++; $display("[TB] FAIL timeout_latency: got %0d cycles, expected 16", lat + 1); end
        @(negedge clk);
        n_checks++;
        if (exp_bus.size() != 0 || exp_done.size() != 0) begin
            n_fail++; $display("[TB] FAIL timeout_drain: got %0d/%0d pending, expected 0/0", exp_bus.size(), exp_done.size());
        end
    endtask

    task automatic test_reset_mid_poll();
        int lat;
        int guard = 0;
        int dc0;
        ack_delay = 3; hit_at = 0;
        push_cmd_writes(14'h0101, 32'h0000_0007);
        while (req_ready !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
        req_cmd = 14'h0101; req_arg = 32'h0000_0007; req_long = 1'b0; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        guard = 0;
        while (!(wb_cyc === 1'b1 && wb_addr === 8'h34) && guard < 100) begin @(negedge clk); guard++; end
        n_checks++;
        if (wb_cyc !== 1'b1 || wb_addr !== 8'h34) begin
            n_fail++; $display("[TB] FAIL poll_reach: got cyc=%b addr=%h, expected 1 34", wb_cyc, wb_addr);
        end
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if (wb_cyc !== 1'b0 || wb_stb !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_drop: got cyc=%b stb=%b, expected 0 0", wb_cyc, wb_stb);
        end
        dc0 = done_count;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || wb_cyc !== 1'b0) begin
            n_fail++; $display("[TB] FAIL after_reset: got ready=%b cyc=%b, expected 1 0", req_ready, wb_cyc);
        end
        n_checks++;
        if (done_count != dc0 || exp_bus.size() != 0) begin
            n_fail++; $display("[TB] FAIL reset_no_done: got dones=%0d pending=%0d, expected %0d 0", done_count, exp_bus.size(), dc0);
        end
        ack_delay = 0; hit_at = 1; hit_ev = 5'h10; words[0] = 32'h0BAD_F00D;
        push_cmd_writes(14'h0102, 32'h0000_0008);
        push_rd(8'h34); push_rd(8'h08); push_wr(8'h34, 32'h0);
        push_done(5'h10, 1'b0, {88'h0, 32'h0BAD_F00D});
        #1;
        run_cmd(14'h0102, 32'h0000_0008, 1'b0, 1'b0, lat);
        n_checks++;
        if (lat + 1 != 12) begin n_fail++; $display("[TB] FAIL recover_latency: got %0d cycles, expected 12", lat + 1); end
        @(negedge clk);
        n_checks++;
        if (exp_bus.size() != 0 || exp_done.size() != 0) begin
            n_fail++; $display("[TB] FAIL recover_drain: got %0d/%0d pending, expected 0/0", exp_bus.size(), exp_done.size());
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        int guard = 0;
        int dc0;
        logic [119:0] resp1;
        ack_delay = 0; hit_at = 1; hit_ev = 5'h02;
        words[0] = 32'h0101_0101; words[1] = 32'h0202_0202; words[2] = 32'h0303_0303; words[3] = 32'hFF04_0404;
        resp1 = {24'h040404, 32'h03030303, 32'h02020202, 32'h01010101};
        push_cmd_writes(14'h0211, 32'h0000_0AAA);
        push_rd(8'h34); push_rd(8'h08); push_rd(8'h0C); push_rd(8'h10); push_rd(8'h14);
        push_wr(8'h34, 32'h0);
        push_done(5'h02, 1'b0, resp1);
        push_cmd_writes(14'h0D37, 32'h0000_0BBB);
        push_rd(8'h34); push_rd(8'h08); push_wr(8'h34, 32'h0);
        push_done(5'h02, 1'b0, {88'h0, 32'h0101_0101});
        dc0 = done_count;
        run_cmd(14'h0211, 32'h0000_0AAA, 1'b1, 1'b1, lat);
        req_cmd = 14'h0D37; req_arg = 32'h0000_0BBB; req_long = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || done_resp !== resp1) begin
            n_fail++; $display("[TB] FAIL b2b_idle: got ready=%b resp=%h, expected 1 %h", req_ready, done_resp, resp1);
        end
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b0 || done_resp !== 120'h0 || wb_cyc !== 1'b1 || wb_addr !== 8'h04) begin
            n_fail++; $display("[TB] FAIL b2b_accept: got ready=%b resp=%h cyc=%b addr=%h, expected 0 0 1 04",
                               req_ready, done_resp, wb_cyc, wb_addr);
        end
        req_valid = 1'b0;
        while (done_count < dc0 + 2 && guard < 200) begin @(negedge clk); guard++; end
        @(negedge clk);
        n_checks++;
        if (done_count != dc0 + 2 || exp_bus.size() != 0 || exp_done.size() != 0) begin
            n_fail++; $display("[TB] FAIL b2b_drain: got dones=%0d pending=%0d/%0d, expected %0d 0/0",
                               done_count - dc0, exp_bus.size(), exp_done.size(), 2);
        end
    endtask

    initial begin
        fork
            run_monitor();
        join_none
        test_reset();
        test_min_latency();
        test_short(0, 16);
        test_long();
        test_timeout();
        test_short(3, 37);
        test_reset_mid_poll();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
